// File: rtl/i2c_seq_pkg.sv
// Shared types for the I2C transaction sequencer: FSM states, phase kinds, error codes,
// and the helpers that place each phase within a transaction.
package i2c_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_GAP,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } state_t;

  typedef enum logic [2:0] {
    PH_ADDR_W,
    PH_REG,
    PH_WDATA,
    PH_ADDR_R,
    PH_RDATA
  } phase_kind_t;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_NACK    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_BADCNT  = 2'd3;

  localparam int MAX_BYTES = 4;

  // Phase layout: 0 = addr(W), 1 = reg, then data bytes for a write,
  // or 2 = addr(R) followed by read bytes for a read.
  function automatic phase_kind_t phase_kind(input logic [2:0] idx, input logic is_read);
    if (idx == 3'd0) return PH_ADDR_W;
    if (idx == 3'd1) return PH_REG;
    if (!is_read)    return PH_WDATA;
    if (idx == 3'd2) return PH_ADDR_R;
    return PH_RDATA;
  endfunction

  function automatic logic [2:0] last_phase(input logic is_read, input logic [2:0] count);
    return is_read ? count + 3'd2 : count + 3'd1;
  endfunction

endpackage

// File: rtl/i2c_transaction_sequencer_phase_timer.sv
// Per-phase watchdog: counts enabled cycles since the last clear and flags when the
// count reaches TIMEOUT_CYCLES; the count saturates there until cleared.
module i2c_phase_timer #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TIMER_W        = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TIMER_W-1:0] count;

  assign expired = (count == TIMER_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_transaction_sequencer.sv
// Runs a full I2C register write or read as a sequence of byte-level controller phases,
// one request in, one done pulse out with an error code and left-aligned read data.
module i2c_transaction_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TIMER_W        = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [6:0]  req_dev_addr,
  input  logic [7:0]  req_reg_addr,
  input  logic        req_is_read,
  input  logic [2:0]  req_count,
  input  logic [31:0] req_wdata,
  output logic        done,
  output logic [1:0]  err_code,
  output logic [31:0] rdata,
  output logic        i2c_trigger,
  output logic        i2c_restart,
  output logic        i2c_last_byte,
  output logic [6:0]  i2c_address,
  output logic        i2c_read_write,
  output logic [7:0]  i2c_write_data,
  input  logic [7:0]  i2c_read_data,
  input  logic        i2c_ack_error,
  input  logic        i2c_busy
);

  state_t      state;
  logic [2:0]  phase_idx;
  logic [2:0]  last_idx;
  logic        lat_read;
  logic [7:0]  lat_reg;
  logic [31:0] lat_wdata;

  logic        req_fire;
  logic        req_read_eff;
  logic        timer_clear;
  logic        timer_en;
  logic        timer_expired;

  logic [2:0]  nxt_idx;
  phase_kind_t nxt_kind;
  phase_kind_t cur_kind;
  logic [2:0]  wsel;
  logic [2:0]  rsel;
  logic [31:0] wshift;
  logic [7:0]  nxt_wdata;
  logic [31:0] rdata_ins;

  assign req_ready    = (state == ST_IDLE) && !i2c_busy;
  assign req_fire     = req_valid && req_ready;
  // A read with no data bytes degenerates to a pointer-only write.
  assign req_read_eff = req_is_read && (req_count != 3'd0);
  assign timer_clear  = (state == ST_ISSUE);
  assign timer_en     = (state == ST_GAP) || (state == ST_WAIT);

  always_comb begin
    nxt_idx   = phase_idx + 3'd1;
    nxt_kind  = phase_kind(nxt_idx, lat_read);
    cur_kind  = phase_kind(phase_idx, lat_read);
    wsel      = nxt_idx - 3'd2;
    rsel      = phase_idx - 3'd3;
    wshift    = lat_wdata << {wsel, 3'b000};
    rdata_ins = {i2c_read_data, 24'h000000} >> {rsel, 3'b000};
    nxt_wdata = 8'h00;
    case (nxt_kind)
      PH_REG:   nxt_wdata = lat_reg;
      PH_WDATA: nxt_wdata = wshift[31:24];
      default:  nxt_wdata = 8'h00;
    endcase
  end

  i2c_phase_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMER_W        (TIMER_W)
  ) u_phase_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      phase_idx      <= 3'd0;
      last_idx       <= 3'd0;
      lat_read       <= 1'b0;
      lat_reg        <= 8'h00;
      lat_wdata      <= 32'h0;
      done           <= 1'b0;
      err_code       <= ERR_OK;
      rdata          <= 32'h0;
      i2c_trigger    <= 1'b0;
      i2c_restart    <= 1'b0;
      i2c_last_byte  <= 1'b0;
      i2c_address    <= 7'h00;
      i2c_read_write <= 1'b0;
      i2c_write_data <= 8'h00;
    end else begin
      i2c_trigger <= 1'b0;
      done        <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_fire) begin
            rdata          <= 32'h0;
            err_code       <= ERR_OK;
            lat_read       <= req_read_eff;
            lat_reg        <= req_reg_addr;
            lat_wdata      <= req_wdata;
            phase_idx      <= 3'd0;
            last_idx       <= last_phase(req_read_eff, req_count);
            i2c_address    <= req_dev_addr;
            i2c_read_write <= 1'b0;
            i2c_write_data <= 8'h00;
            i2c_last_byte  <= 1'b0;
            if (req_count > 3'(MAX_BYTES)) begin
              i2c_restart <= 1'b0;
              err_code    <= ERR_BADCNT;
              done        <= 1'b1;
              state       <= ST_DONE;
            end else begin
              i2c_restart <= 1'b1;
              i2c_trigger <= 1'b1;
              state       <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: state <= ST_GAP;
        // The controller may not have raised busy yet, so GAP never looks at it.
        ST_GAP:   state <= ST_WAIT;
        ST_WAIT: begin
          if (!i2c_busy) begin
            state <= ST_CHECK;
          end else if (timer_expired) begin
            err_code      <= ERR_TIMEOUT;
            i2c_last_byte <= 1'b0;
            done          <= 1'b1;
            state         <= ST_DONE;
          end
        end
        ST_CHECK: begin
          if (i2c_ack_error) begin
            err_code <= ERR_NACK;
            done     <= 1'b1;
            state    <= ST_DONE;
          end else begin
            if (cur_kind == PH_RDATA) begin
              rdata <= rdata | rdata_ins;
            end
            if (phase_idx == last_idx) begin
              err_code <= ERR_OK;
              done     <= 1'b1;
              state    <= ST_DONE;
            end else begin
              phase_idx      <= nxt_idx;
              i2c_restart    <= (nxt_kind == PH_ADDR_R);
              i2c_read_write <= (nxt_kind == PH_ADDR_R) || (nxt_kind == PH_RDATA);
              i2c_write_data <= nxt_wdata;
              i2c_last_byte  <= (nxt_idx == last_idx);
              i2c_trigger    <= 1'b1;
              state          <= ST_ISSUE;
            end
          end
        end
        ST_DONE: begin
          i2c_last_byte <= 1'b0;
          state         <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_transaction_sequencer.sv
// Directed bench: a behavioural byte controller plus a transaction-level model of the
// expected trigger sequence, result code and read data, checked every negedge.
module tb_i2c_transaction_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  req_dev_addr;
  logic [7:0]  req_reg_addr;
  logic        req_is_read;
  logic [2:0]  req_count;
  logic [31:0] req_wdata;
  logic        done;
  logic [1:0]  err_code;
  logic [31:0] rdata;
  logic        i2c_trigger;
  logic        i2c_restart;
  logic        i2c_last_byte;
  logic [6:0]  i2c_address;
  logic        i2c_read_write;
  logic [7:0]  i2c_write_data;
  logic [7:0]  i2c_read_data;
  logic        i2c_ack_error;
  logic        i2c_busy;

  i2c_transaction_sequencer #(.TIMEOUT_CYCLES(20), .TIMER_W(16)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dev_addr(req_dev_addr), .req_reg_addr(req_reg_addr),
    .req_is_read(req_is_read), .req_count(req_count), .req_wdata(req_wdata),
    .done(done), .err_code(err_code), .rdata(rdata),
    .i2c_trigger(i2c_trigger), .i2c_restart(i2c_restart), .i2c_last_byte(i2c_last_byte),
    .i2c_address(i2c_address), .i2c_read_write(i2c_read_write),
    .i2c_write_data(i2c_write_data), .i2c_read_data(i2c_read_data),
    .i2c_ack_error(i2c_ack_error), .i2c_busy(i2c_busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       restart;
    logic       rw;
    logic       last;
    logic       chk_wd;
    logic [6:0] addr;
    logic [7:0] wd;
  } trig_t;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  int          cyc    = 0;

  trig_t       exp_q[$];
  logic [1:0]  exp_err;
  logic [31:0] exp_rdata;
  logic [7:0]  rbytes[4];
  bit          txn_open = 0;
  int          ntrig = 0;
  int          last_trig_cyc = 0;
  int          done_cyc = 0;
  int          acc_cyc = 0;

  int          busy_len = 3;
  bit          stuck = 0;
  int          nack_at = -1;
  int          phase_no = 0;
  int          rd_ptr = 0;
  int          busy_left = 0;
  logic [7:0]  pend_rd;
  logic        pend_nack;
  int          waits;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Transaction-level expectation: which bytes go out, in which order, and the outcome.
  task automatic build_model(input logic [6:0] dev, input logic [7:0] rg, input bit rd,
                             input int cnt, input logic [31:0] wd, input bit stuck_m);
    bit rd_eff;
    int total;
    exp_q.delete();
    exp_rdata = 32'h0;
    exp_err   = 2'd0;
    if (cnt > 4) begin
      exp_err = 2'd3;
      return;
    end
    rd_eff = rd && (cnt > 0);
    total  = rd_eff ? cnt + 3 : cnt + 2;
    for (int i = 0; i < total; i++) begin
      trig_t t;
      t.addr = dev; t.last = (i == total - 1); t.chk_wd = 1'b0; t.wd = 8'h00;
      t.restart = 1'b0; t.rw = 1'b0;
      if (i == 0) begin
        t.restart = 1'b1;
      end else if (i == 1) begin
        t.chk_wd = 1'b1; t.wd = rg;
      end else if (!rd_eff) begin
        t.chk_wd = 1'b1; t.wd = wd[31 - 8*(i-2) -: 8];
      end else if (i == 2) begin
        t.restart = 1'b1; t.rw = 1'b1;
      end else begin
        t.rw = 1'b1;
        if (nack_at != i) exp_rdata[31 - 8*(i-3) -: 8] = rbytes[i-3];
      end
      exp_q.push_back(t);
      if (stuck_m) begin exp_err = 2'd2; break; end
      if (i == nack_at) begin exp_err = 2'd1; break; end
    end
  endtask

  // Behavioural byte controller: busy from the trigger cycle for busy_len cycles.
  initial begin
    i2c_busy = 1'b0; i2c_ack_error = 1'b0; i2c_read_data = 8'h00;
    pend_rd = 8'h00; pend_nack = 1'b0;
    forever begin
      @(posedge clock); #1;
      if (reset) begin
        i2c_busy = 1'b0; busy_left = 0;
      end else if (i2c_trigger) begin
        pend_nack = (phase_no == nack_at);
        pend_rd   = 8'h00;
        if (!i2c_restart && i2c_read_write && rd_ptr < 4) begin
          pend_rd = rbytes[rd_ptr];
          rd_ptr++;
        end
        phase_no++;
        i2c_ack_error = 1'b0;
        i2c_busy  = 1'b1;
        busy_left = busy_len;
      end else if (i2c_busy && !stuck) begin
        busy_left--;
        if (busy_left <= 0) begin
          i2c_busy = 1'b0; i2c_ack_error = pend_nack; i2c_read_data = pend_rd;
        end
      end
    end
  end

  // Compare process.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (i2c_trigger) begin
          ntrig++;
          last_trig_cyc = cyc;
          if (exp_q.size() == 0) begin
            check("unexpected_trigger", 32'd1, 32'd0);
          end else begin
            trig_t e;
            e = exp_q.pop_front();
            check("trig_restart", {31'd0, i2c_restart}, {31'd0, e.restart});
            check("trig_rw", {31'd0, i2c_read_write}, {31'd0, e.rw});
            check("trig_addr", {25'd0, i2c_address}, {25'd0, e.addr});
            check("trig_last", {31'd0, i2c_last_byte}, {31'd0, e.last});
            if (e.chk_wd) check("trig_wdata", {24'd0, i2c_write_data}, {24'd0, e.wd});
          end
        end
        if (done) begin
          if (!txn_open) begin
            check("unexpected_done", 32'd1, 32'd0);
          end else begin
            check("done_err", {30'd0, err_code}, {30'd0, exp_err});
            check("done_rdata", rdata, exp_rdata);
            check("done_leftover_phases", exp_q.size(), 32'd0);
            done_cyc = cyc;
            txn_open = 0;
          end
        end
      end
    end
  end

  task automatic do_req(input logic [6:0] dev, input logic [7:0] rg, input bit rd,
                        input int cnt, input logic [31:0] wd, output int nwait);
    bit acc = 0;
    #1;
    req_dev_addr = dev; req_reg_addr = rg; req_is_read = rd;
    req_count = 3'(cnt); req_wdata = wd; req_valid = 1'b1;
    nwait = 0;
    while (!acc && nwait < 100) begin
      @(negedge clock);
      if (req_ready) begin acc = 1; acc_cyc = cyc; end
      else nwait++;
      @(posedge clock);
    end
    #1 req_valid = 1'b0;
    if (!acc) check("req_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_txn(input logic [6:0] dev, input logic [7:0] rg, input bit rd,
                         input int cnt, input logic [31:0] wd, input int nack, input bit stuck_m,
                         output int nwait);
    int n = 0;
    nack_at = nack; stuck = stuck_m; phase_no = 0; rd_ptr = 0;
    build_model(dev, rg, rd, cnt, wd, stuck_m);
    ntrig = 0;
    txn_open = 1;
    do_req(dev, rg, rd, cnt, wd, nwait);
    while (txn_open && n < 400) begin
      @(posedge clock);
      n++;
    end
    if (txn_open) begin
      check("done_timeout", 32'd1, 32'd0);
      txn_open = 0;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_err"}, {30'd0, err_code}, 32'd0);
    check({tag, "_rdata"}, rdata, 32'd0);
    check({tag, "_trigger"}, {31'd0, i2c_trigger}, 32'd0);
    check({tag, "_restart"}, {31'd0, i2c_restart}, 32'd0);
    check({tag, "_last"}, {31'd0, i2c_last_byte}, 32'd0);
    check({tag, "_addr"}, {25'd0, i2c_address}, 32'd0);
    check({tag, "_rw"}, {31'd0, i2c_read_write}, 32'd0);
    check({tag, "_wdata"}, {24'd0, i2c_write_data}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_dev_addr = 7'h00; req_reg_addr = 8'h00;
    req_is_read = 1'b0; req_count = 3'd0; req_wdata = 32'h0;
    rbytes[0] = 8'h00; rbytes[1] = 8'h00; rbytes[2] = 8'h00; rbytes[3] = 8'h00;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_outputs_zero("reset");
    @(posedge clock); #1 reset = 1'b0;
    repeat (2) @(posedge clock);

    // Register write, two data bytes.
    run_txn(7'h50, 8'h10, 1'b0, 2, 32'hAABB0000, -1, 1'b0, waits);
    check("wr2_ntrig", ntrig, 32'd4);
    check("wr2_err", {30'd0, err_code}, 32'd0);

    // Register read, three data bytes.
    rbytes[0] = 8'h11; rbytes[1] = 8'h22; rbytes[2] = 8'h33; rbytes[3] = 8'h44;
    run_txn(7'h68, 8'h3B, 1'b1, 3, 32'h0, -1, 1'b0, waits);
    check("rd3_ntrig", ntrig, 32'd6);
    check("rd3_rdata", rdata, 32'h11223300);

    // Pointer-only, as write and as zero-length read.
    run_txn(7'h50, 8'h07, 1'b0, 0, 32'h0, -1, 1'b0, waits);
    check("wr0_ntrig", ntrig, 32'd2);
    run_txn(7'h50, 8'h07, 1'b1, 0, 32'h0, -1, 1'b0, waits);
    check("rd0_ntrig", ntrig, 32'd2);
    check("rd0_rdata", rdata, 32'h0);

    // NACK on the address phase, then an immediate follow-on request.
    run_txn(7'h50, 8'h20, 1'b0, 1, 32'h77000000, 0, 1'b0, waits);
    check("nack_ntrig", ntrig, 32'd1);
    check("nack_err", {30'd0, err_code}, 32'd1);
    run_txn(7'h51, 8'h02, 1'b0, 1, 32'hC3000000, -1, 1'b0, waits);
    check("b2b_accept_wait", waits, 32'd0);
    check("b2b_ntrig", ntrig, 32'd3);

    // Illegal count.
    run_txn(7'h50, 8'h00, 1'b0, 5, 32'h0, -1, 1'b0, waits);
    check("badcnt_ntrig", ntrig, 32'd0);
    check("badcnt_err", {30'd0, err_code}, 32'd3);
    check("badcnt_latency", done_cyc - acc_cyc, 32'd1);

    // Controller busy stuck: watchdog fires.
    run_txn(7'h50, 8'h10, 1'b0, 2, 32'h12340000, -1, 1'b1, waits);
    check("timeout_err", {30'd0, err_code}, 32'd2);
    check("timeout_latency_20_to_22",
          {31'd0, (done_cyc - last_trig_cyc <= 22) && (done_cyc - last_trig_cyc >= 20)}, 32'd1);
    check("timeout_last_cleared", {31'd0, i2c_last_byte}, 32'd0);
    stuck = 0;
    repeat (6) @(posedge clock);

    // Reset mid-WAIT: outputs clear at once, no done pulse.
    busy_len = 8; nack_at = -1; phase_no = 0; rd_ptr = 0;
    build_model(7'h68, 8'h3B, 1'b1, 2, 32'h0, 1'b0);
    ntrig = 0; txn_open = 1;
    do_req(7'h68, 8'h3B, 1'b1, 2, 32'h0, waits);
    for (int n = 0; n < 50 && ntrig < 1; n++) @(posedge clock);
    check("rst_first_trigger_seen", {31'd0, ntrig >= 1}, 32'd1);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    txn_open = 0; exp_q.delete();
    #1 check_outputs_zero("midrst");
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    repeat (10) @(posedge clock);

    // Recovery after reset.
    busy_len = 3;
    run_txn(7'h2A, 8'h01, 1'b0, 1, 32'h5A000000, -1, 1'b0, waits);
    check("recover_ntrig", ntrig, 32'd3);
    repeat (4) @(posedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
